// File: rtl/h14tx_rst_pkg.sv
// Shared types and default constants for the TMDS-root reset sequencer.
// Holds the sequencer state encoding and default timing parameters.
package h14tx_rst_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StGuard   = 2'd1,
    StRelease = 2'd2,
    StRun     = 2'd3
  } state_t;

  localparam int RstGuardWidth = 4;
  localparam int RstStagger    = 8;
  localparam int RstLockFilter = 4;

endpackage

// File: rtl/h14tx_rst_seq_sync_ff.sv
// Generic multi-flop synchroniser, synchronous reset to zero.
// Ports: i_clk, i_rst (sync, active-high), i_d[Width], o_q[Width].
module h14tx_sync_ff
  import h14tx_rst_pkg::*;
#(
  parameter int Width  = 1,
  parameter int Stages = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_stg [Stages];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < Stages; i++) r_stg[i] <= '0;
    end else begin
      r_stg[0] <= i_d;
      for (int i = 1; i < Stages; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_q = r_stg[Stages-1];

endmodule

// File: rtl/h14tx_rst_seq.sv
// Reset sequencer: syncs ext_rst_n/lock, filters lock, then releases
// NumOut active-low resets in index order, StaggerCycles apart.
// Ports: clk, rst (sync, active-high), ext_rst_n, lock (async inputs),
//   sync_rst_n[NumOut], ready, lock_loss_cnt[8] (H14TX_RST_SEQ_STATS_EN).
module h14tx_rst_seq
  import h14tx_rst_pkg::*;
#(
  parameter int NumOut        = 3,
  parameter int GuardWidth    = RstGuardWidth,
  parameter int StaggerCycles = RstStagger,
  parameter int LockFilter    = RstLockFilter
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_rst_n,
  input  logic              lock,
  output logic [NumOut-1:0] sync_rst_n,
`ifdef H14TX_RST_SEQ_STATS_EN
  output logic [7:0]        lock_loss_cnt,
`endif
  output logic              ready
);

  localparam int SW = $clog2(StaggerCycles + 1);
  localparam int RW = $clog2(NumOut + 1);
  localparam int LW = $clog2(LockFilter + 1);

  localparam logic [GuardWidth-1:0] GuardMax = '1;
  localparam logic [SW-1:0] StagMax = SW'(StaggerCycles - 1);
  localparam logic [RW-1:0] RelMax  = RW'(NumOut);
  localparam logic [LW-1:0] LfMax   = LW'(LockFilter - 1);

  generate
    if (NumOut < 1) begin : g_bad_numout
      $error("NumOut must be >= 1");
    end
    if (StaggerCycles < 1) begin : g_bad_stagger
      $error("StaggerCycles must be >= 1");
    end
    if (LockFilter < 1) begin : g_bad_filter
      $error("LockFilter must be >= 1");
    end
  endgenerate

  logic [1:0] w_sync;
  logic       w_ext_s;
  logic       w_lock_s;

  h14tx_sync_ff #(
    .Width  (2),
    .Stages (2)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   ({ext_rst_n, lock}),
    .o_q   (w_sync)
  );

  assign {w_ext_s, w_lock_s} = w_sync;

  // Rising lock is filtered; a single low sample drops it at once.
  logic [LW-1:0] r_lf_cnt;
  logic          r_lock_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lf_cnt <= '0;
      r_lock_q <= 1'b0;
    end else if (!w_lock_s) begin
      r_lf_cnt <= '0;
      r_lock_q <= 1'b0;
    end else if (r_lf_cnt == LfMax) begin
      r_lock_q <= 1'b1;
    end else begin
      r_lf_cnt <= r_lf_cnt + LW'(1);
    end
  end

  logic w_qual;
  assign w_qual = w_ext_s && r_lock_q;

  state_t          r_state, w_state_nxt;
  logic [GuardWidth-1:0] r_guard_cnt, w_guard_nxt;
  logic [SW-1:0]   r_stag_cnt, w_stag_nxt;
  logic [RW-1:0]   r_rel_cnt, w_rel_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StAssert;
      r_guard_cnt <= '0;
      r_stag_cnt  <= '0;
      r_rel_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_guard_cnt <= w_guard_nxt;
      r_stag_cnt  <= w_stag_nxt;
      r_rel_cnt   <= w_rel_nxt;
    end
  end

  // Loss of qual wins over every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_guard_nxt = r_guard_cnt;
    w_stag_nxt  = r_stag_cnt;
    w_rel_nxt   = r_rel_cnt;
    unique case (r_state)
      StAssert: begin
        w_guard_nxt = '0;
        w_stag_nxt  = '0;
        w_rel_nxt   = '0;
        if (w_qual) w_state_nxt = StGuard;
      end
      StGuard: begin
        if (!w_qual) begin
          w_state_nxt = StAssert;
        end else if (r_guard_cnt == GuardMax) begin
          w_state_nxt = StRelease;
          w_rel_nxt   = RW'(1);
          w_stag_nxt  = '0;
        end else begin
          w_guard_nxt = r_guard_cnt + GuardWidth'(1);
        end
      end
      StRelease: begin
        if (!w_qual) begin
          w_state_nxt = StAssert;
        end else if (r_rel_cnt >= RelMax) begin
          w_state_nxt = StRun;
        end else if (r_stag_cnt == StagMax) begin
          w_rel_nxt  = r_rel_cnt + RW'(1);
          w_stag_nxt = '0;
        end else begin
          w_stag_nxt = r_stag_cnt + SW'(1);
        end
      end
      StRun: begin
        if (!w_qual) w_state_nxt = StAssert;
      end
      default: w_state_nxt = StAssert;
    endcase
  end

  logic [NumOut-1:0] w_rst_n;

  always_comb begin
    w_rst_n = '0;
    for (int i = 0; i < NumOut; i++) begin
      w_rst_n[i] = (r_state == StRun) ||
                   ((r_state == StRelease) && (RW'(i) < r_rel_cnt));
    end
  end

  assign sync_rst_n = w_rst_n;
  assign ready      = &w_rst_n;

`ifdef H14TX_RST_SEQ_STATS_EN
  logic [7:0] r_loss_cnt;
  logic       w_loss_evt;

  // Only drops caused by lock count; ext-only drops are ignored.
  assign w_loss_evt = ((r_state == StRelease) || (r_state == StRun)) &&
                      !r_lock_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_h14tx_rst_seq.sv
// Self-checking bench for h14tx_rst_seq (default and 1-output instances).
// Expected outputs come from a release-time model via a scoreboard queue.
module tb_h14tx_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       ext_rst_n;
  logic       lock;
  logic [2:0] sync_rst_n;
  logic       ready;
  logic [0:0] rn1;
  logic       rdy1;
`ifdef H14TX_RST_SEQ_STATS_EN
  logic [7:0] llc;
  logic [7:0] llc1;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] rn;
    logic       rdy;
    logic       rn1;
  } exp_t;

  exp_t sb[$];
  int   sq[$];

  always #5 clk = ~clk;

  h14tx_rst_seq dut (
    .clk        (clk),
    .rst        (rst),
    .ext_rst_n  (ext_rst_n),
    .lock       (lock),
    .sync_rst_n (sync_rst_n),
`ifdef H14TX_RST_SEQ_STATS_EN
    .lock_loss_cnt (llc),
`endif
    .ready      (ready)
  );

  h14tx_rst_seq #(
    .NumOut        (1),
    .GuardWidth    (2),
    .StaggerCycles (1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .ext_rst_n  (ext_rst_n),
    .lock       (lock),
    .sync_rst_n (rn1),
`ifdef H14TX_RST_SEQ_STATS_EN
    .lock_loss_cnt (llc1),
`endif
    .ready      (rdy1)
  );

  // tq: cycle in which qual first goes high.
  // 3-output: bit i at tq+17+8i. 1-output: bit at tq+5.
  function automatic exp_t model(int n, int tq);
    exp_t e;
    for (int i = 0; i < 3; i++) e.rn[i] = (n >= tq + 17 + 8 * i);
    e.rdy = &e.rn;
    e.rn1 = (n >= tq + 5);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    ext_rst_n = 1'b1;
    lock = 1'b1;
    for (int n = 1; n <= 3; n++) sb.push_back(model(n, 1000));
    for (int n = 1; n <= 3; n++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({sync_rst_n, ready, rn1, rdy1} !== {e.rn, e.rdy, e.rn1, e.rn1}) begin
        failures++;
        $display("FAIL reset n=%0d got rn=%b rdy=%b rn1=%b rdy1=%b exp rn=%b rdy=%b rn1=%b",
                 n, sync_rst_n, ready, rn1, rdy1, e.rn, e.rdy, e.rn1);
      end
    end
  endtask

  task automatic test_sequence();
    exp_t e;
    rst = 1'b0;
    for (int n = 1; n <= 44; n++) sb.push_back(model(n, 6));
    for (int n = 1; n <= 44; n++) begin
      cyc();
      e = sb.pop_front();
      checks++;
      if ({sync_rst_n, ready, rn1, rdy1} !== {e.rn, e.rdy, e.rn1, e.rn1}) begin
        failures++;
        $display("FAIL sequence n=%0d got rn=%b rdy=%b rn1=%b rdy1=%b exp rn=%b rdy=%b rn1=%b",
                 n, sync_rst_n, ready, rn1, rdy1, e.rn, e.rdy, e.rn1);
      end
    end
  endtask

  task automatic test_lock_drop();
    exp_t e;
    lock = 1'b0;
    for (int n = 1; n <= 48; n++)
      sb.push_back(n < 4 ? model(n, -100) : model(n, 8));
    for (int n = 1; n <= 48; n++) begin
      cyc();
      if (n == 2) lock = 1'b1;
      e = sb.pop_front();
      checks++;
      if ({sync_rst_n, ready, rn1, rdy1} !== {e.rn, e.rdy, e.rn1, e.rn1}) begin
        failures++;
        $display("FAIL lock_drop n=%0d got rn=%b rdy=%b rn1=%b rdy1=%b exp rn=%b rdy=%b rn1=%b",
                 n, sync_rst_n, ready, rn1, rdy1, e.rn, e.rdy, e.rn1);
      end
    end
  endtask

  task automatic test_lock_glitch();
    exp_t e;
    lock = 1'b0;
    repeat (10) cyc();
    lock = 1'b1;
    for (int n = 1; n <= 40; n++) sb.push_back(model(n, 1000));
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (n == 3) lock = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({sync_rst_n, ready, rn1, rdy1} !== {e.rn, e.rdy, e.rn1, e.rn1}) begin
        failures++;
        $display("FAIL lock_glitch n=%0d got rn=%b rdy=%b rn1=%b exp rn=%b",
                 n, sync_rst_n, ready, rn1, e.rn);
      end
    end
  endtask

  task automatic test_ext_rst();
    exp_t e;
    lock = 1'b1;
    for (int n = 1; n <= 75; n++)
      sb.push_back(n < 36 ? model(n, 6) : model(n, 39));
    for (int n = 1; n <= 75; n++) begin
      cyc();
      if (n == 33) ext_rst_n = 1'b0;
      if (n == 37) ext_rst_n = 1'b1;
      e = sb.pop_front();
      checks++;
      if ({sync_rst_n, ready, rn1, rdy1} !== {e.rn, e.rdy, e.rn1, e.rn1}) begin
        failures++;
        $display("FAIL ext_rst n=%0d got rn=%b rdy=%b rn1=%b rdy1=%b exp rn=%b rdy=%b rn1=%b",
                 n, sync_rst_n, ready, rn1, rdy1, e.rn, e.rdy, e.rn1);
      end
    end
  endtask

  task automatic test_rst_in_run();
    exp_t e;
`ifdef H14TX_RST_SEQ_STATS_EN
    for (int k = 1; k <= 5; k++) begin
      lock = 1'b0;
      repeat (6) cyc();
      lock = 1'b1;
      repeat (45) cyc();
    end
    checks++;
    if (llc !== 8'd5 || llc1 !== 8'd5) begin
      failures++;
      $display("FAIL stats_pre got %0d/%0d exp 5", llc, llc1);
    end
`endif
    rst = 1'b1;
    sb.push_back(model(1, 1000));
    cyc();
    rst = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({sync_rst_n, ready, rn1, rdy1} !== {e.rn, e.rdy, e.rn1, e.rn1}) begin
      failures++;
      $display("FAIL rst_in_run got rn=%b rdy=%b rn1=%b exp rn=%b",
               sync_rst_n, ready, rn1, e.rn);
    end
`ifdef H14TX_RST_SEQ_STATS_EN
    checks++;
    if (llc !== 8'd0 || llc1 !== 8'd0) begin
      failures++;
      $display("FAIL stats_rst got %0d/%0d exp 0", llc, llc1);
    end
`endif
    repeat (45) cyc();
    checks++;
    if (sync_rst_n !== 3'b111 || ready !== 1'b1) begin
      failures++;
      $display("FAIL rerun got rn=%b rdy=%b exp 111/1", sync_rst_n, ready);
    end
  endtask

`ifdef H14TX_RST_SEQ_STATS_EN
  task automatic test_stats_sat();
    int x;
    for (int k = 1; k <= 300; k++) begin
      lock = 1'b0;
      sq.push_back(k > 255 ? 255 : k);
      repeat (6) cyc();
      lock = 1'b1;
      repeat (45) cyc();
      x = sq.pop_front();
      checks++;
      if (llc !== x[7:0]) begin
        failures++;
        $display("FAIL stats_sat k=%0d got %0d exp %0d", k, llc, x);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_lock_drop();
    test_lock_glitch();
    test_ext_rst();
    test_rst_in_run();
`ifdef H14TX_RST_SEQ_STATS_EN
    test_stats_sat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/h14tx_rst_seq.md
Name: h14tx_rst_seq

Overview:
Parametrised reset sequencer, successor to the single-output reset sync. Synchronises the external reset and PLL lock inputs and filters lock glitches. After a guard interval it releases NumOut downstream active-low resets one at a time, in index order, spaced StaggerCycles apart. It sits at the TMDS/pixel clock root and drives the encoder, serialiser and packet-scheduler resets. Any loss of lock or external reset re-asserts all outputs.

Parameters:
NumOut, 3, number of sequenced reset outputs (>=1)
GuardWidth, 4, guard interval is 2**GuardWidth cycles
StaggerCycles, 8, cycles between successive output releases (>=1)
LockFilter, 4, consecutive high samples of synced lock needed before lock is qualified (>=1)

Ports:
clk  input  1  sequencer clock
rst  input  1  synchronous, active-high reset
ext_rst_n  input  1  asynchronous external reset request, active-low
lock  input  1  asynchronous PLL lock indication
sync_rst_n  output  NumOut  sequenced active-low resets; bit 0 released first
ready  output  1  high when all outputs are released

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Under rst: state=Assert, synchroniser stages 0, all counters 0, sync_rst_n='0, ready=0.
- Input sync: ext_rst_n and lock each pass through a 2-flop synchroniser, giving ext_s and lock_s.
- Lock filter: lock_q sets after LockFilter consecutive cycles of lock_s=1. It clears in the same cycle that lock_s=0 is seen, with no filtering on the falling edge.
- qual = ext_s && lock_q.
- State machine (state_t: Assert, Guard, Release, Run):
  - Assert: go to Guard when qual=1.
  - Guard: guard_cnt increments from 0. At guard_cnt == 2**GuardWidth-1, go to Release with rel_cnt=1 and stag_cnt=0.
  - Release: stag_cnt increments. At stag_cnt == StaggerCycles-1, rel_cnt increments and stag_cnt clears. When rel_cnt reaches NumOut, go to Run.
  - Run: hold.
  - From Guard, Release or Run: qual=0 goes to Assert next cycle. This takes priority over every other transition, including guard terminal count.
- Outputs are decoded from registers only, with no combinational path from inputs.
  - sync_rst_n[i] = 1 iff state is Release or Run and i < rel_cnt.
  - In Run all bits are 1.
  - ready = &sync_rst_n.
- Latency, with qual first high in cycle T:
  - sync_rst_n[0] rises at T+1+2**GuardWidth.
  - sync_rst_n[i] rises i*StaggerCycles cycles after bit 0.
  - ready rises with the last bit.
- Re-assertion: when qual drops in any state, all bits fall together in the next cycle. Outputs never release out of order.
- Counter widths: guard_cnt is GuardWidth bits and wraps only by terminal compare. stag_cnt is $clog2(StaggerCycles+1) bits. rel_cnt is $clog2(NumOut+1) bits.
- Elaboration assertions: NumOut>=1, StaggerCycles>=1, LockFilter>=1.

Optional Feature:
H14TX_RST_SEQ_STATS_EN
- Defined: adds output lock_loss_cnt [7:0].
  - Increments by 1 on each Release->Assert or Run->Assert transition caused by lock_q=0.
  - Saturates at 255; transitions caused by ext_s=0 are not counted.
  - Cleared only by rst.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package h14tx_rst_pkg holds:
  - state_t enum
  - default parameter constants: RstGuardWidth, RstStagger, RstLockFilter.
- Sub-module h14tx_sync_ff: generic N-flop synchroniser with Width and Stages parameters and synchronous reset value 0. Instantiated once with Width=2 for {ext_rst_n, lock}.
- Top contains the lock filter, FSM, counters and output decode.

Test Plan:
- Defaults; rst released; lock=1 and ext_rst_n=1 held.
  - qual rises at cycle T; sync_rst_n goes 3'b001 at T+17, 3'b011 at T+25, 3'b111 at T+33.
  - ready=1 at T+33 and not before.
- In Run, drive lock=0 for 2 cycles.
  - All sync_rst_n=0 and ready=0 exactly 4 cycles after the pin falls (2 sync, 1 filter, 1 FSM).
  - Full resequence follows once lock_q requalifies.
- From Assert, pulse lock high for 3 cycles, then low.
  - lock_q never sets; state stays Assert; sync_rst_n=3'b000 throughout.
- During Release at sync_rst_n=3'b011, drive ext_rst_n=0.
  - Outputs go to 3'b000 together.
  - After ext_rst_n returns, the guard restarts from 0 and the full 17/25/33 timing repeats.
- Assert rst for one cycle during Run with STATS_EN and lock_loss_cnt=5.
  - Next cycle: sync_rst_n=0, ready=0, lock_loss_cnt=0.
  - Separately, 300 lock drops in Run leave lock_loss_cnt at 255.
- Instance with NumOut=1, StaggerCycles=1, GuardWidth=2.
  - sync_rst_n[0] and ready both rise at T+5.
